jtag_tap_controller: RTL
========================

Name: jtag_tap_controller

Overview:
- IEEE 1149.1-style TAP controller that drives the control pins of the boundary-scan cell chain: CAPTURE, UPDATE, MODE_SHIFT_LOAD and MODE_TEST_NORMAL.
- Holds the instruction register and the 1-bit bypass register.
- Selects TDO between the IR, the bypass bit and the tail of the boundary chain.
- Sits between the device JTAG pins and the first and last boundary cells.

Parameters:
- IR_WIDTH, 4, instruction register width (minimum 2).
- EXTEST_CODE, 4'b0000, opcode that puts the cells in test mode.
- SAMPLE_CODE, 4'b0001, SAMPLE/PRELOAD opcode. Cells stay in normal mode; the boundary chain is selected.
- The all-ones opcode is BYPASS. Every undefined opcode behaves as BYPASS.

Ports:
- TCK  in  1  single clock. The FSM and IR update on posedge. Output-control flops update on negedge.
- RST  in  1  asynchronous reset, active-high.
- TMS  in  1  test mode select.
- TDI  in  1  serial data in.
- TDIS  out  1  serial data into the first boundary cell; equals TDI combinationally.
- TDOS_CHAIN  in  1  TDOS of the last boundary cell.
- CAPTURE  out  1  boundary-cell capture/shift clock (gated TCK).
- UPDATE  out  1  boundary-cell update clock.
- MODE_SHIFT_LOAD  out  1  1 = cells shift TDIS; 0 = cells load SYSTEM_DATA_IN.
- MODE_TEST_NORMAL  out  1  1 = normal (system passthrough); 0 = test (update_reg drives pin).
- TDO  out  1  serial data out.
- TDO_EN  out  1  TDO output enable.
- STATE  out  4  current TAP state, for debug.
- IR  out  IR_WIDTH  current (updated) instruction.

Behaviour:

FSM:
- 16 standard TAP states, encoded 0..15 in this order: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR.
- Transitions on posedge TCK per IEEE 1149.1. Entries below are given as TMS=0 / TMS=1.
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - SEL_IR: CAP_IR / TLR
  - CAP_x: SH_x / EX1_x
  - SH_x: SH_x / EX1_x
  - EX1_x: PA_x / UPD_x
  - PA_x: PA_x / EX2_x
  - EX2_x: SH_x / UPD_x
  - UPD_x: RTI / SEL_DR
- Five consecutive TMS=1 cycles reach TLR from any state.

Reset:
- RST=1 asynchronously forces:
  - STATE=TLR
  - IR shift register = all ones
  - IR = all ones (BYPASS)
  - bypass bit = 0
  - TDO=0, TDO_EN=0, CAPTURE=0, UPDATE=0, MODE_SHIFT_LOAD=0, MODE_TEST_NORMAL=1
- Entering TLR via TMS also loads IR = all ones on the same edge.
- RST asserted mid-shift aborts the shift. No UPDATE pulse is produced.

IR:
- CAP_IR loads the shift register with {IR_WIDTH-2 zeros, 2'b01}.
- In SH_IR, shifts right on posedge: MSB takes TDI, LSB goes to TDO.
- The parallel IR loads from the shift register on negedge TCK in UPD_IR.

Bypass:
- Captures 0 in CAP_DR when BYPASS is selected.
- Takes TDI in SH_DR.

DR select:
- Boundary chain is selected when IR == EXTEST_CODE or SAMPLE_CODE.
- Otherwise the bypass bit is selected.

Cell controls (enables latched on negedge TCK):
- CAPTURE = TCK AND cap_en.
  - cap_en is set on negedge while STATE is CAP_DR or SH_DR and the boundary chain is selected.
  - The CAPTURE rising edge therefore coincides with the TCK edge that leaves that state.
  - No glitches: cap_en changes only while TCK is low.
- UPDATE: flop set on the negedge where STATE=UPD_DR and the boundary chain is selected; cleared on the next negedge. High for exactly one TCK period.
- MODE_SHIFT_LOAD = 1 on negedge when STATE=SH_DR; otherwise 0. It is stable before the CAPTURE rising edge.
- MODE_TEST_NORMAL = 0 while IR == EXTEST_CODE; otherwise 1. Updated on the same negedge as the IR load.

TDO:
- Registered on negedge TCK:
  - SH_IR: IR shift LSB.
  - SH_DR: TDOS_CHAIN or the bypass bit, per DR select.
- TDO_EN = 1 only during SH_IR or SH_DR (latched on negedge). Otherwise TDO=0 and TDO_EN=0.

Test Plan:
- Assert RST mid-SH_DR, release, then check idle state → STATE=0, IR=4'b1111, MODE_TEST_NORMAL=1, CAPTURE/UPDATE silent, TDO_EN=0.
- From RTI, drive TMS=1,1,1,1,1 → STATE=TLR after the 5th edge.
- Repeat from every one of the 16 states → TLR in ≤5 edges in each case.
- Shift IR=4'b0000 (EXTEST) via SEL_DR→SEL_IR→CAP_IR→SH_IR → TDO emits 1,0,0,0 (capture pattern). After UPD_IR: IR=0 and MODE_TEST_NORMAL falls to 0 on that negedge.
- With EXTEST loaded, run CAP_DR then 3×SH_DR then EX1→UPD_DR, with a 3-cell chain model:
  - Exactly 4 CAPTURE rising edges.
  - MODE_SHIFT_LOAD=0 at the 1st edge and 1 at the next 3.
  - One UPDATE pulse, one TCK wide.
  - Chain pattern 3'b101 from TDI appears at the cell outputs.
- Load BYPASS (4'b1111), shift DR with TDI=1,0,1,1 → TDO=0,1,0,1 (one-cycle delay). CAPTURE and UPDATE never toggle.
- Load SAMPLE_CODE, capture with SYSTEM_DATA_IN=1 on every cell, shift out → TDO shows 1,1,1. MODE_TEST_NORMAL stays 1 throughout.
- Pass through PA_DR/EX2_DR mid-shift with TCK running → no CAPTURE edges while in PA_DR. Shift resumes with data intact.

Source files
------------

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1-style TAP controller: state machine, instruction and bypass registers,
// boundary-cell control generation and TDO multiplexing.
module jtag_tap_controller #(
  parameter int                  IR_WIDTH    = 4,
  parameter logic [IR_WIDTH-1:0] EXTEST_CODE = '0,
  parameter logic [IR_WIDTH-1:0] SAMPLE_CODE = IR_WIDTH'(1)
) (
  input  logic                TCK,
  input  logic                RST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDIS,
  input  logic                TDOS_CHAIN,
  output logic                CAPTURE,
  output logic                UPDATE,
  output logic                MODE_SHIFT_LOAD,
  output logic                MODE_TEST_NORMAL,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [3:0]          STATE,
  output logic [IR_WIDTH-1:0] IR
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PA_DR  = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PA_IR  = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IR_ONES    = '1;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_e          state;
  tap_state_e          next_state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir_q;
  logic                bypass_bit;
  logic                chain_sel;
  logic                cap_en;
  logic                update_q;
  logic                shift_load_q;
  logic                test_normal_q;
  logic                tdo_q;
  logic                tdo_en_q;

  // Entering TLR forces BYPASS on that same posedge; ir_q catches up on the next negedge.
  assign IR        = (state == TLR) ? IR_ONES : ir_q;
  assign chain_sel = (IR == EXTEST_CODE) || (IR == SAMPLE_CODE);

  assign STATE            = state;
  assign TDIS             = TDI;
  assign CAPTURE          = TCK & cap_en;
  assign UPDATE           = update_q;
  assign MODE_SHIFT_LOAD  = shift_load_q;
  assign MODE_TEST_NORMAL = test_normal_q;
  assign TDO              = tdo_q;
  assign TDO_EN           = tdo_en_q;

  always_ff @(posedge TCK or posedge RST) begin
    if (RST) begin
      state <= TLR;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      TLR:    next_state = TMS ? TLR    : RTI;
      RTI:    next_state = TMS ? SEL_DR : RTI;
      SEL_DR: next_state = TMS ? SEL_IR : CAP_DR;
      CAP_DR: next_state = TMS ? EX1_DR : SH_DR;
      SH_DR:  next_state = TMS ? EX1_DR : SH_DR;
      EX1_DR: next_state = TMS ? UPD_DR : PA_DR;
      PA_DR:  next_state = TMS ? EX2_DR : PA_DR;
      EX2_DR: next_state = TMS ? UPD_DR : SH_DR;
      UPD_DR: next_state = TMS ? SEL_DR : RTI;
      SEL_IR: next_state = TMS ? TLR    : CAP_IR;
      CAP_IR: next_state = TMS ? EX1_IR : SH_IR;
      SH_IR:  next_state = TMS ? EX1_IR : SH_IR;
      EX1_IR: next_state = TMS ? UPD_IR : PA_IR;
      PA_IR:  next_state = TMS ? EX2_IR : PA_IR;
      EX2_IR: next_state = TMS ? UPD_IR : SH_IR;
      UPD_IR: next_state = TMS ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  // Instruction shift path and bypass bit move on the rising edge with the state.
  always_ff @(posedge TCK or posedge RST) begin
    if (RST) begin
      ir_shift   <= IR_ONES;
      bypass_bit <= 1'b0;
    end else begin
      if (state == CAP_IR) begin
        ir_shift <= IR_CAPTURE;
      end else if (state == SH_IR) begin
        ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
      end
      if (state == CAP_DR && !chain_sel) begin
        bypass_bit <= 1'b0;
      end else if (state == SH_DR) begin
        bypass_bit <= TDI;
      end
    end
  end

  // Everything facing the cells and the TDO pin changes while TCK is low, so CAPTURE
  // cannot glitch and the mode pins are settled before the next rising edge.
  always_ff @(negedge TCK or posedge RST) begin
    if (RST) begin
      ir_q          <= IR_ONES;
      test_normal_q <= 1'b1;
      cap_en        <= 1'b0;
      update_q      <= 1'b0;
      shift_load_q  <= 1'b0;
      tdo_q         <= 1'b0;
      tdo_en_q      <= 1'b0;
    end else begin
      if (state == UPD_IR) begin
        ir_q          <= ir_shift;
        test_normal_q <= (ir_shift != EXTEST_CODE);
      end else if (state == TLR) begin
        ir_q          <= IR_ONES;
        test_normal_q <= 1'b1;
      end
      cap_en       <= ((state == CAP_DR) || (state == SH_DR)) && chain_sel;
      update_q     <= (state == UPD_DR) && chain_sel;
      shift_load_q <= (state == SH_DR);
      if (state == SH_IR) begin
        tdo_q    <= ir_shift[0];
        tdo_en_q <= 1'b1;
      end else if (state == SH_DR) begin
        tdo_q    <= chain_sel ? TDOS_CHAIN : bypass_bit;
        tdo_en_q <= 1'b1;
      end else begin
        tdo_q    <= 1'b0;
        tdo_en_q <= 1'b0;
      end
    end
  end

endmodule
